// File: rtl/fpu_issue_queue_pkg.sv
// Shared core package for the FP issue path.
//   opcode_t         FP opcode encoding used by dispatch and the FPU
//   fpu_iq_entry_t   one issue-queue slot: op fields, source tags and ready bits
//   FPU_IQ_N_SRC     sources tracked per op: a, b, c and the FCR source
// Ready bit order in fpu_iq_entry_t.rdy is {fcr, c, b, a}.
package fpu_issue_queue_pkg;

  localparam int LG_PRF_WIDTH = 4;
  localparam int LG_ROB_WIDTH = 4;
  localparam int LG_FCR_WIDTH = 4;
  localparam int FPU_IQ_N_SRC = 4;

  typedef enum logic [3:0] {
    SP_ADD  = 4'd0,
    DP_ADD  = 4'd1,
    SP_SUB  = 4'd2,
    DP_SUB  = 4'd3,
    SP_MUL  = 4'd4,
    DP_MUL  = 4'd5,
    SP_DIV  = 4'd6,
    DP_DIV  = 4'd7,
    SP_MADD = 4'd8,
    DP_MADD = 4'd9,
    SP_CMP  = 4'd10,
    DP_CMP  = 4'd11,
    SP_CVT  = 4'd12,
    DP_CVT  = 4'd13,
    FMOV    = 4'd14,
    FNOP    = 4'd15
  } opcode_t;

  typedef struct packed {
    opcode_t                   opcode;
    logic [LG_ROB_WIDTH-1:0]   rob_ptr;
    logic [LG_PRF_WIDTH-1:0]   dst_ptr;
    logic [LG_FCR_WIDTH-1:0]   fcr_ptr;
    logic [2:0]                fcr_sel;
    logic [LG_PRF_WIDTH-1:0]   src_a_ptr;
    logic [LG_PRF_WIDTH-1:0]   src_b_ptr;
    logic [LG_PRF_WIDTH-1:0]   src_c_ptr;
    logic [LG_FCR_WIDTH-1:0]   src_fcr_ptr;
    logic [FPU_IQ_N_SRC-1:0]   rdy;
  } fpu_iq_entry_t;

endpackage

// File: rtl/fpu_issue_queue_if.sv
// Bundle between dispatch/writeback/FPU and the FP issue queue.
//   slave  : the queue's view (enqueue + wakeup in, issue bundle out)
//   master : the environment's view (drives enqueue, flush and wakeups)
// Handshake: an op transfers at a rising edge where enq_val && enq_rdy.
// enq_rdy depends only on registered state. start is a one-cycle strobe;
// the issue fields hold their last value while start is low.
interface fpu_issue_queue_if #(
  parameter int N_ENTRIES = 4
);
  import fpu_issue_queue_pkg::*;

  localparam int OCC_W = $clog2(N_ENTRIES) + 1;

  logic                    flush;
  logic                    enq_val;
  logic                    enq_rdy;
  opcode_t                 enq_opcode;
  logic [LG_ROB_WIDTH-1:0] enq_rob_ptr;
  logic [LG_PRF_WIDTH-1:0] enq_dst_ptr;
  logic [LG_FCR_WIDTH-1:0] enq_fcr_ptr;
  logic [2:0]              enq_fcr_sel;
  logic [LG_PRF_WIDTH-1:0] enq_src_a_ptr;
  logic [LG_PRF_WIDTH-1:0] enq_src_b_ptr;
  logic [LG_PRF_WIDTH-1:0] enq_src_c_ptr;
  logic [LG_FCR_WIDTH-1:0] enq_src_fcr_ptr;
  logic [3:0]              enq_src_rdy;
  logic                    wake_prf_val;
  logic [LG_PRF_WIDTH-1:0] wake_prf_ptr;
  logic                    wake_fcr_val;
  logic [LG_FCR_WIDTH-1:0] wake_fcr_ptr;
  logic                    start;
  opcode_t                 opcode;
  logic [LG_ROB_WIDTH-1:0] rob_ptr;
  logic [LG_PRF_WIDTH-1:0] dst_ptr;
  logic [LG_FCR_WIDTH-1:0] fcr_ptr;
  logic [2:0]              fcr_sel;
  logic [LG_PRF_WIDTH-1:0] src_a_ptr;
  logic [LG_PRF_WIDTH-1:0] src_b_ptr;
  logic [LG_PRF_WIDTH-1:0] src_c_ptr;
  logic [LG_FCR_WIDTH-1:0] src_fcr_ptr;
  logic [OCC_W-1:0]        occupancy;

  modport slave (
    input  flush, enq_val, enq_opcode, enq_rob_ptr, enq_dst_ptr, enq_fcr_ptr,
           enq_fcr_sel, enq_src_a_ptr, enq_src_b_ptr, enq_src_c_ptr,
           enq_src_fcr_ptr, enq_src_rdy, wake_prf_val, wake_prf_ptr,
           wake_fcr_val, wake_fcr_ptr,
    output enq_rdy, start, opcode, rob_ptr, dst_ptr, fcr_ptr, fcr_sel,
           src_a_ptr, src_b_ptr, src_c_ptr, src_fcr_ptr, occupancy
  );

  modport master (
    output flush, enq_val, enq_opcode, enq_rob_ptr, enq_dst_ptr, enq_fcr_ptr,
           enq_fcr_sel, enq_src_a_ptr, enq_src_b_ptr, enq_src_c_ptr,
           enq_src_fcr_ptr, enq_src_rdy, wake_prf_val, wake_prf_ptr,
           wake_fcr_val, wake_fcr_ptr,
    input  enq_rdy, start, opcode, rob_ptr, dst_ptr, fcr_ptr, fcr_sel,
           src_a_ptr, src_b_ptr, src_c_ptr, src_fcr_ptr, occupancy
  );

endinterface

// File: rtl/fpu_iq_wakeup.sv
// Tag comparison for one op's four sources against the writeback broadcasts.
//   src_*_ptr, rdy_in   source tags and current ready bits {fcr,c,b,a}
//   wake_*              PRF / FCR writeback broadcasts
//   rdy_nxt             ready bits including a same-cycle wakeup hit
module fpu_iq_wakeup
  import fpu_issue_queue_pkg::*;
(
  input  logic [LG_PRF_WIDTH-1:0] src_a_ptr,
  input  logic [LG_PRF_WIDTH-1:0] src_b_ptr,
  input  logic [LG_PRF_WIDTH-1:0] src_c_ptr,
  input  logic [LG_FCR_WIDTH-1:0] src_fcr_ptr,
  input  logic [FPU_IQ_N_SRC-1:0] rdy_in,
  input  logic                    wake_prf_val,
  input  logic [LG_PRF_WIDTH-1:0] wake_prf_ptr,
  input  logic                    wake_fcr_val,
  input  logic [LG_FCR_WIDTH-1:0] wake_fcr_ptr,
  output logic [FPU_IQ_N_SRC-1:0] rdy_nxt
);

  assign rdy_nxt[0] = rdy_in[0] | (wake_prf_val && (src_a_ptr == wake_prf_ptr));
  assign rdy_nxt[1] = rdy_in[1] | (wake_prf_val && (src_b_ptr == wake_prf_ptr));
  assign rdy_nxt[2] = rdy_in[2] | (wake_prf_val && (src_c_ptr == wake_prf_ptr));
  assign rdy_nxt[3] = rdy_in[3] | (wake_fcr_val && (src_fcr_ptr == wake_fcr_ptr));

endmodule

// File: rtl/fpu_issue_queue.sv
// In-order FP issue queue. Holds renamed ops until their sources are ready
// and issues the head op (one per cycle) onto a registered FPU bundle.
//   clk, reset_n   clock and asynchronous active-low reset
//   io (slave)     enqueue, flush, wakeup inputs; start/op/tag outputs,
//                  enq_rdy and occupancy
module fpu_issue_queue
  import fpu_issue_queue_pkg::*;
#(
  parameter int N_ENTRIES = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  fpu_issue_queue_if.slave    io
);

  localparam int PW = $clog2(N_ENTRIES);
  localparam logic [PW:0] FULL_CNT = (PW + 1)'(N_ENTRIES);

  fpu_iq_entry_t           ent_q [N_ENTRIES];
  logic [N_ENTRIES-1:0]    valid_q;
  logic [PW-1:0]           head_q;
  logic [PW-1:0]           tail_q;
  logic [PW:0]             count_q;
  logic [FPU_IQ_N_SRC-1:0] ent_rdy_nxt [N_ENTRIES];
  logic [FPU_IQ_N_SRC-1:0] enq_rdy_nxt;
  fpu_iq_entry_t           enq_ent;
  logic                    enq_fire;
  logic                    issue_fire;

  for (genvar i = 0; i < N_ENTRIES; i++) begin : g_wake
    fpu_iq_wakeup u_wake (
      .src_a_ptr    (ent_q[i].src_a_ptr),
      .src_b_ptr    (ent_q[i].src_b_ptr),
      .src_c_ptr    (ent_q[i].src_c_ptr),
      .src_fcr_ptr  (ent_q[i].src_fcr_ptr),
      .rdy_in       (ent_q[i].rdy),
      .wake_prf_val (io.wake_prf_val),
      .wake_prf_ptr (io.wake_prf_ptr),
      .wake_fcr_val (io.wake_fcr_val),
      .wake_fcr_ptr (io.wake_fcr_ptr),
      .rdy_nxt      (ent_rdy_nxt[i])
    );
  end

  // Incoming op sees the same-cycle broadcast so it is never missed.
  fpu_iq_wakeup u_wake_enq (
    .src_a_ptr    (io.enq_src_a_ptr),
    .src_b_ptr    (io.enq_src_b_ptr),
    .src_c_ptr    (io.enq_src_c_ptr),
    .src_fcr_ptr  (io.enq_src_fcr_ptr),
    .rdy_in       (io.enq_src_rdy),
    .wake_prf_val (io.wake_prf_val),
    .wake_prf_ptr (io.wake_prf_ptr),
    .wake_fcr_val (io.wake_fcr_val),
    .wake_fcr_ptr (io.wake_fcr_ptr),
    .rdy_nxt      (enq_rdy_nxt)
  );

  always_comb begin
    enq_ent             = '0;
    enq_ent.opcode      = io.enq_opcode;
    enq_ent.rob_ptr     = io.enq_rob_ptr;
    enq_ent.dst_ptr     = io.enq_dst_ptr;
    enq_ent.fcr_ptr     = io.enq_fcr_ptr;
    enq_ent.fcr_sel     = io.enq_fcr_sel;
    enq_ent.src_a_ptr   = io.enq_src_a_ptr;
    enq_ent.src_b_ptr   = io.enq_src_b_ptr;
    enq_ent.src_c_ptr   = io.enq_src_c_ptr;
    enq_ent.src_fcr_ptr = io.enq_src_fcr_ptr;
    enq_ent.rdy         = enq_rdy_nxt;
  end

  assign io.enq_rdy   = (count_q != FULL_CNT);
  assign io.occupancy = count_q;
  assign enq_fire     = io.enq_val && io.enq_rdy;
  // Head readiness includes the wakeup bypass for this cycle.
  assign issue_fire   = valid_q[head_q] && (&ent_rdy_nxt[head_q]);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N_ENTRIES; i++) ent_q[i] <= '0;
      valid_q        <= '0;
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      io.start       <= 1'b0;
      io.opcode      <= SP_ADD;
      io.rob_ptr     <= '0;
      io.dst_ptr     <= '0;
      io.fcr_ptr     <= '0;
      io.fcr_sel     <= '0;
      io.src_a_ptr   <= '0;
      io.src_b_ptr   <= '0;
      io.src_c_ptr   <= '0;
      io.src_fcr_ptr <= '0;
    end else if (io.flush) begin
      valid_q  <= '0;
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      io.start <= 1'b0;
    end else begin
      for (int i = 0; i < N_ENTRIES; i++) ent_q[i].rdy <= ent_rdy_nxt[i];
      io.start <= issue_fire;
      // With both firing, tail != head: issue needs count>=1, enqueue count<N.
      if (enq_fire) begin
        ent_q[tail_q]   <= enq_ent;
        valid_q[tail_q] <= 1'b1;
        tail_q          <= tail_q + 1'b1;
      end
      if (issue_fire) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + 1'b1;
        io.opcode       <= ent_q[head_q].opcode;
        io.rob_ptr      <= ent_q[head_q].rob_ptr;
        io.dst_ptr      <= ent_q[head_q].dst_ptr;
        io.fcr_ptr      <= ent_q[head_q].fcr_ptr;
        io.fcr_sel      <= ent_q[head_q].fcr_sel;
        io.src_a_ptr    <= ent_q[head_q].src_a_ptr;
        io.src_b_ptr    <= ent_q[head_q].src_b_ptr;
        io.src_c_ptr    <= ent_q[head_q].src_c_ptr;
        io.src_fcr_ptr  <= ent_q[head_q].src_fcr_ptr;
      end
      case ({enq_fire, issue_fire})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_issue_queue.sv
// Bench for fpu_issue_queue: directed scenarios followed by random traffic,
// checked against a queue-of-ops reference model.
module tb_fpu_issue_queue;
  import fpu_issue_queue_pkg::*;

  localparam int N = 4;
  localparam int W = 35;

  logic clk = 1'b0;
  logic reset_n;

  fpu_issue_queue_if #(.N_ENTRIES(N)) bif ();

  fpu_issue_queue #(.N_ENTRIES(N)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .io      (bif.slave)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [W-1:0]  exp_q[$];
  fpu_iq_entry_t m_q[$];
  logic          exp_start;
  logic [W-1:0]  last_fields;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] pack_ent(input fpu_iq_entry_t e);
    return {e.opcode, e.rob_ptr, e.dst_ptr, e.fcr_ptr, e.fcr_sel,
            e.src_a_ptr, e.src_b_ptr, e.src_c_ptr, e.src_fcr_ptr};
  endfunction

  function automatic logic [W-1:0] dut_fields();
    return {bif.opcode, bif.rob_ptr, bif.dst_ptr, bif.fcr_ptr, bif.fcr_sel,
            bif.src_a_ptr, bif.src_b_ptr, bif.src_c_ptr, bif.src_fcr_ptr};
  endfunction

  // A source becomes ready when a broadcast names its tag.
  function automatic fpu_iq_entry_t apply_wake(input fpu_iq_entry_t e);
    fpu_iq_entry_t r = e;
    if (bif.wake_prf_val) begin
      if (r.src_a_ptr == bif.wake_prf_ptr) r.rdy[0] = 1'b1;
      if (r.src_b_ptr == bif.wake_prf_ptr) r.rdy[1] = 1'b1;
      if (r.src_c_ptr == bif.wake_prf_ptr) r.rdy[2] = 1'b1;
    end
    if (bif.wake_fcr_val && r.src_fcr_ptr == bif.wake_fcr_ptr) r.rdy[3] = 1'b1;
    return r;
  endfunction

  // Advance the model by one clock edge using the inputs now being driven.
  task automatic model_step();
    int sz;
    fpu_iq_entry_t e;
    sz = m_q.size();
    exp_start = 1'b0;
    if (bif.flush) begin
      m_q.delete();
    end else begin
      for (int i = 0; i < sz; i++) m_q[i] = apply_wake(m_q[i]);
      if (sz > 0 && m_q[0].rdy == 4'hF) begin
        last_fields = pack_ent(m_q[0]);
        exp_q.push_back(last_fields);
        void'(m_q.pop_front());
        exp_start = 1'b1;
      end
      if (bif.enq_val && sz < N) begin
        e.opcode      = bif.enq_opcode;
        e.rob_ptr     = bif.enq_rob_ptr;
        e.dst_ptr     = bif.enq_dst_ptr;
        e.fcr_ptr     = bif.enq_fcr_ptr;
        e.fcr_sel     = bif.enq_fcr_sel;
        e.src_a_ptr   = bif.enq_src_a_ptr;
        e.src_b_ptr   = bif.enq_src_b_ptr;
        e.src_c_ptr   = bif.enq_src_c_ptr;
        e.src_fcr_ptr = bif.enq_src_fcr_ptr;
        e.rdy         = bif.enq_src_rdy;
        m_q.push_back(apply_wake(e));
      end
    end
  endtask

  // One clock: model, edge, compare outputs, return at the falling edge.
  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    check("start", bif.start, exp_start);
    check("occupancy", bif.occupancy, m_q.size());
    check("enq_rdy", bif.enq_rdy, (m_q.size() < N));
    check("fields", dut_fields(), last_fields);
    if (bif.start) begin
      if (exp_q.size() > 0) check("issue_order", dut_fields(), exp_q.pop_front());
      else check("issue_unexpected", bif.start, 1'b0);
    end
    exp_q.delete();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    bif.flush = 0; bif.enq_val = 0; bif.enq_opcode = SP_ADD;
    bif.enq_rob_ptr = 0; bif.enq_dst_ptr = 0; bif.enq_fcr_ptr = 0;
    bif.enq_fcr_sel = 0; bif.enq_src_a_ptr = 0; bif.enq_src_b_ptr = 0;
    bif.enq_src_c_ptr = 0; bif.enq_src_fcr_ptr = 0; bif.enq_src_rdy = 4'hF;
    bif.wake_prf_val = 0; bif.wake_prf_ptr = 0;
    bif.wake_fcr_val = 0; bif.wake_fcr_ptr = 0;
  endtask

  task automatic set_enq(input opcode_t op, input logic [3:0] rob, input logic [3:0] dst,
                         input logic [3:0] a, input logic [3:0] b, input logic [3:0] rdy);
    bif.enq_val = 1; bif.enq_opcode = op; bif.enq_rob_ptr = rob;
    bif.enq_dst_ptr = dst; bif.enq_fcr_ptr = rob; bif.enq_fcr_sel = 3'd1;
    bif.enq_src_a_ptr = a; bif.enq_src_b_ptr = b; bif.enq_src_c_ptr = 4'd0;
    bif.enq_src_fcr_ptr = 4'd0; bif.enq_src_rdy = rdy;
  endtask

  initial begin
    reset_n = 1'b0;
    clear_inputs();
    exp_start = 1'b0;
    last_fields = '0;
    repeat (2) @(negedge clk);
    check("rst_start", bif.start, 1'b0);
    check("rst_occupancy", bif.occupancy, 0);
    check("rst_enq_rdy", bif.enq_rdy, 1'b1);
    check("rst_fields", dut_fields(), '0);
    reset_n = 1'b1;

    // Single ready op: minimum latency.
    set_enq(DP_ADD, 4'd3, 4'd5, 4'd0, 4'd0, 4'hF);
    step();
    bif.enq_val = 0;
    step();
    check("lat_start", bif.start, 1'b1);
    check("lat_rob", bif.rob_ptr, 4'd3);
    check("lat_dst", bif.dst_ptr, 4'd5);
    step();

    // Blocked on src_a tag 7 until woken.
    set_enq(SP_MUL, 4'd1, 4'd2, 4'd7, 4'd0, 4'b1110);
    step();
    bif.enq_val = 0;
    repeat (6) step();
    check("blocked_start", bif.start, 1'b0);
    bif.wake_prf_val = 1; bif.wake_prf_ptr = 4'd7;
    step();
    check("wake_start", bif.start, 1'b1);
    bif.wake_prf_val = 0;
    step();

    // Fill with a blocked head, then release it.
    set_enq(DP_MUL, 4'd9, 4'd1, 4'd9, 4'd0, 4'b1110);
    step();
    for (int i = 0; i < 3; i++) begin
      set_enq(SP_ADD, 4'(10 + i), 4'(i), 4'd0, 4'd0, 4'hF);
      step();
    end
    set_enq(FMOV, 4'd15, 4'd15, 4'd0, 4'd0, 4'hF);
    step();
    check("full_enq_rdy", bif.enq_rdy, 1'b0);
    check("full_occupancy", bif.occupancy, 4);
    bif.enq_val = 0;
    bif.wake_prf_val = 1; bif.wake_prf_ptr = 4'd9;
    step();
    bif.wake_prf_val = 0;
    check("release_rob", bif.rob_ptr, 4'd9);
    check("release_enq_rdy", bif.enq_rdy, 1'b1);
    repeat (4) step();

    // Wakeup on src_b in the enqueue cycle.
    set_enq(DP_DIV, 4'd4, 4'd6, 4'd0, 4'd6, 4'b1101);
    bif.wake_prf_val = 1; bif.wake_prf_ptr = 4'd6;
    step();
    bif.enq_val = 0; bif.wake_prf_val = 0;
    step();
    check("enq_wake_start", bif.start, 1'b1);
    step();

    // Flush with three queued and the head becoming ready; enqueue dropped.
    set_enq(SP_SUB, 4'd5, 4'd1, 4'd11, 4'd0, 4'b1110);
    step();
    set_enq(SP_SUB, 4'd6, 4'd2, 4'd0, 4'd0, 4'hF);
    step();
    set_enq(SP_SUB, 4'd7, 4'd3, 4'd0, 4'd0, 4'hF);
    step();
    set_enq(SP_SUB, 4'd8, 4'd4, 4'd0, 4'd0, 4'hF);
    bif.flush = 1; bif.wake_prf_val = 1; bif.wake_prf_ptr = 4'd11;
    step();
    check("flush_occupancy", bif.occupancy, 0);
    clear_inputs();
    step();
    check("flush_no_start", bif.start, 1'b0);

    // Reset while start is high.
    set_enq(DP_CMP, 4'd2, 4'd8, 4'd0, 4'd0, 4'hF);
    step();
    bif.enq_val = 0;
    step();
    check("pre_reset_start", bif.start, 1'b1);
    reset_n = 1'b0;
    #1;
    check("async_start", bif.start, 1'b0);
    m_q.delete();
    last_fields = '0;
    @(negedge clk);
    reset_n = 1'b1;
    check("post_reset_occ", bif.occupancy, 0);
    check("post_reset_enq_rdy", bif.enq_rdy, 1'b1);
    check("post_reset_fields", dut_fields(), '0);

    // Random traffic.
    for (int c = 0; c < 1500; c++) begin
      bif.enq_val         = ($urandom_range(0, 2) != 0);
      bif.enq_opcode      = opcode_t'($urandom_range(0, 15));
      bif.enq_rob_ptr     = 4'($urandom_range(0, 15));
      bif.enq_dst_ptr     = 4'($urandom_range(0, 15));
      bif.enq_fcr_ptr     = 4'($urandom_range(0, 15));
      bif.enq_fcr_sel     = 3'($urandom_range(0, 7));
      bif.enq_src_a_ptr   = 4'($urandom_range(0, 15));
      bif.enq_src_b_ptr   = 4'($urandom_range(0, 15));
      bif.enq_src_c_ptr   = 4'($urandom_range(0, 15));
      bif.enq_src_fcr_ptr = 4'($urandom_range(0, 15));
      for (int s = 0; s < 4; s++) bif.enq_src_rdy[s] = ($urandom_range(0, 3) != 0);
      bif.wake_prf_val    = ($urandom_range(0, 1) != 0);
      bif.wake_prf_ptr    = 4'($urandom_range(0, 15));
      bif.wake_fcr_val    = ($urandom_range(0, 1) != 0);
      bif.wake_fcr_ptr    = 4'($urandom_range(0, 15));
      bif.flush           = ($urandom_range(0, 99) == 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fpu_issue_queue.md
# fpu_issue_queue

In-order issue queue that feeds the fixed-latency FPU execution unit. It accepts renamed FP ops from dispatch, holds them until their physical sources are ready, and issues them one at a time in program order. On issue it drives the FPU-side start/opcode/pointer bundle and the PRF/FCR read tags. Readiness comes from enqueue-time ready bits plus the writeback wakeup broadcasts.

## Interface
- N_ENTRIES, 4, queue depth; power of two, ≥2
- LG_PRF_WIDTH, 4, physical FP register tag width
- LG_ROB_WIDTH, 4, ROB pointer width
- LG_FCR_WIDTH, 4, physical FCR tag width

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous squash of all queued ops
- enq_val  in  1  dispatch presents an op
- enq_rdy  out  1  queue can accept; equals !full
- enq_opcode  in  opcode_t  FP opcode
- enq_rob_ptr  in  LG_ROB_WIDTH  ROB slot
- enq_dst_ptr  in  LG_PRF_WIDTH  destination PRF tag
- enq_fcr_ptr  in  LG_FCR_WIDTH  destination FCR tag
- enq_fcr_sel  in  3  condition-code bit index
- enq_src_a_ptr / enq_src_b_ptr / enq_src_c_ptr  in  LG_PRF_WIDTH each  source PRF tags
- enq_src_fcr_ptr  in  LG_FCR_WIDTH  source FCR tag
- enq_src_rdy  in  4  ready bits {fcr,c,b,a}; dispatch sets 1 for unused sources
- wake_prf_val / wake_prf_ptr  in  1 / LG_PRF_WIDTH  PRF writeback broadcast
- wake_fcr_val / wake_fcr_ptr  in  1 / LG_FCR_WIDTH  FCR writeback broadcast
- start  out  1  one-cycle issue strobe to FPU
- opcode, rob_ptr, dst_ptr, fcr_ptr, fcr_sel  out  per enq_*  issued op fields
- src_a_ptr, src_b_ptr, src_c_ptr, src_fcr_ptr  out  per enq_*  read tags for the issued op
- occupancy  out  $clog2(N_ENTRIES)+1  valid entry count

## Operation
- Circular buffer: head and tail pointers of $clog2(N_ENTRIES) bits plus a count. Pointers wrap modulo N_ENTRIES.
- Enqueue fires on enq_val && enq_rdy and writes the entry at tail. Stored ready bits = enq_src_rdy OR a same-cycle wakeup match on that source.
- Wakeup: every valid entry sets its ready bit for each PRF source whose tag equals wake_prf_ptr while wake_prf_val=1. FCR sources do the same with wake_fcr_*.
- Issue condition: head entry is valid, and each of its four sources is either already ready or matched by a wakeup in the current cycle.
- On issue, the head entry is popped at the edge and its fields are registered onto the outputs. start=1 for exactly one cycle.
- The queue issues at most one op per cycle and never issues out of order.
- Enqueue and issue may fire in the same cycle, including at occupancy N_ENTRIES-1. When occupancy is N_ENTRIES, enq_rdy=0, so enqueue and issue cannot both fire.
- flush takes priority over enqueue and issue in the same cycle. It clears every valid bit, sets head=tail=count=0, and forces start=0 at that edge.
- Output fields hold their last issued values while start=0. Consumers qualify them with start.

## Timing
- Reset (reset_n=0, asynchronous): start=0, occupancy=0, enq_rdy=1, head=tail=0, all valid bits 0. All output fields reset to 0.
- An op enqueued at edge k with all sources ready issues at edge k+1, so start is high in the cycle after k+1. Minimum enqueue-to-start latency is 2 cycles.
- A wakeup in cycle c for a blocked head causes issue at edge c+1 (same-cycle wakeup bypass).
- Back-to-back issue: ready entries issue on consecutive edges, sustaining 1 op/cycle.
- enq_rdy and occupancy are registered-state only; there is no combinational path from enq_val.
- A reset_n assertion mid-issue aborts it; start drops asynchronously.

## Structure
- opcode_t comes from the existing shared core package.
- Add to that package:
  - fpu_iq_entry_t struct: opcode, rob/dst/fcr ptrs, fcr_sel, four source tags, 4-bit ready.
  - Constant FPU_IQ_N_SRC=4.
- Natural sub-module: fpu_iq_wakeup. Per-entry tag comparison producing a 4-bit next-ready vector; instantiated N_ENTRIES times plus once for the enqueue path.

## Test plan
- Reset, then enqueue DP_ADD with enq_src_rdy=4'b1111, rob 3, dst 5 → start=1 two cycles later with rob_ptr=3, dst_ptr=5; occupancy returns to 0.
- Enqueue SP_MUL with src_a not ready (tag 7), then wake_prf_val=1, wake_prf_ptr=7 in cycle c → start in the cycle after edge c+1. With no wakeup, start stays 0 indefinitely.
- Fill 4 entries with head blocked → enq_rdy=0, occupancy=4. Wake the head → issue; enq_rdy=1 next cycle; remaining ready ops issue on consecutive cycles, in order.
- Enqueue an op in the same cycle as a wakeup matching its src_b tag → stored ready bit is 1 and the op issues at minimum latency.
- Assert flush with 3 entries queued and a ready head → no start, occupancy=0. An enqueue in the flush cycle is dropped.
- Assert reset_n=0 while start=1 → start=0 immediately; after release, occupancy=0 and enq_rdy=1.
